// File: rtl/a2d_pkg.sv
// ----------------------------------------------------------------------------
// a2d_pkg
// Shared types and constants for the A2D interface and its SPI engine.
//   state_t        : conversion FSM states
//   CH_*           : ADC channel codes of the three monitored inputs
//   PTR_*          : round-robin pointer codes (lft -> rght -> batt)
//   SPI_* / DIV_*  : 16-bit transactions, SCLK = clk / 32
// ----------------------------------------------------------------------------
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        READ = 2'd3
    } state_t;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    localparam logic [1:0] PTR_LFT  = 2'd0;
    localparam logic [1:0] PTR_RGHT = 2'd1;
    localparam logic [1:0] PTR_BATT = 2'd2;

    localparam int SPI_BITS = 16;
    localparam int SPI_DIV  = 32;
    localparam int DIV_W    = $clog2(SPI_DIV);
    localparam int RISE_W   = $clog2(SPI_BITS) + 1;

    localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(SPI_BITS);

    // Divider landmarks: MSB of the divider is SCLK.
    localparam logic [DIV_W-1:0] DIV_START = {1'b1, {(DIV_W-1){1'b0}}};
    localparam logic [DIV_W-1:0] DIV_RISE  = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_MAX   = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_DONE  = {{(DIV_W-1){1'b1}}, 1'b0};

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == PTR_BATT) ? PTR_LFT : p + 2'd1;
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// ----------------------------------------------------------------------------
// spi_mnrch
// 16-bit SPI master, SCLK = clk/32, idle high, MSB first.
//   clk, rst_n  : clock, async active-low reset
//   wrt         : one-clk start pulse, wt_data captured with it
//   done        : one-clk pulse on the clk SS_n returns high
//   rd_data     : word shifted in from MISO (valid from done onwards)
//   SS_n, SCLK, MOSI, MISO : SPI pins
// SS_n is low for exactly 528 clk per transaction.
// ----------------------------------------------------------------------------
module spi_mnrch
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic [DIV_W-1:0]  div_q;
    logic [RISE_W-1:0] rise_q;
    logic [15:0]       tx_q;
    logic [15:0]       rx_q;
    logic              ss_n_q;
    logic              done_q;
    logic              all_rises;

    assign all_rises = (rise_q == RISE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q <= 1'b1;
            div_q  <= DIV_START;
            rise_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wrt) begin
                ss_n_q <= 1'b0;
                div_q  <= DIV_START;
                rise_q <= '0;
                tx_q   <= wt_data;
            end else if (!ss_n_q) begin
                if (div_q == DIV_MAX && all_rises) begin
                    // Divider is frozen at all-ones so SCLK stays high.
                    ss_n_q <= 1'b1;
                    tx_q   <= '0;
                end else begin
                    div_q <= div_q + 1'b1;
                    if (div_q == DIV_RISE) begin
                        rx_q   <= {rx_q[14:0], MISO};
                        rise_q <= rise_q + 1'b1;
                    end
                    // The fall before the first rise must not shift.
                    if (div_q == DIV_MAX && rise_q != '0)
                        tx_q <= {tx_q[14:0], 1'b0};
                    // Registered so done coincides with SS_n rising.
                    if (div_q == DIV_DONE && all_rises)
                        done_q <= 1'b1;
                end
            end
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = div_q[DIV_W-1];
    assign MOSI    = tx_q[15];
    assign done    = done_q;
    assign rd_data = rx_q;

endmodule

// File: rtl/a2d_intf.sv
// ----------------------------------------------------------------------------
// a2d_intf
// Round-robin sampler of left/right load cells and battery divider through
// an SPI ADC. Each nxt pulse in IDLE runs one command transaction followed by
// one read transaction.
//   clk, rst_n            : clock, async active-low reset
//   nxt                   : request next conversion (ignored unless IDLE)
//   SS_n, SCLK, MOSI, MISO: ADC SPI pins
//   lft_ld, rght_ld, batt : latest 12-bit result per channel
// Latency: the result register updates on the 1059th rising clk edge after
// the edge that samples nxt; with nxt held high the next conversion is
// accepted on the following edge (one IDLE clk between conversions).
//
// state | meaning
// IDLE  | waiting for nxt
// CMD   | command transaction carrying the channel code
// WAIT  | one-clk gap between transactions
// READ  | read transaction, result captured when it completes
// ----------------------------------------------------------------------------
module a2d_intf
    import a2d_pkg::*;
#(
    parameter logic [2:0] LFT_CH  = CH_LFT,
    parameter logic [2:0] RGHT_CH = CH_RGHT,
    parameter logic [2:0] BATT_CH = CH_BATT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt
);

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic        wrt_q;
    logic [15:0] tx_q;
    logic [11:0] lft_q;
    logic [11:0] rght_q;
    logic [11:0] batt_q;
    logic [2:0]  chnl_sel;
    logic        done;
    logic [15:0] rd_data;
    logic [3:0]  rd_unused;

    assign rd_unused = rd_data[15:12];

    always_comb begin
        chnl_sel = LFT_CH;
        case (ptr_q)
            PTR_RGHT: chnl_sel = RGHT_CH;
            PTR_BATT: chnl_sel = BATT_CH;
            default:  chnl_sel = LFT_CH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_LFT;
            wrt_q   <= 1'b0;
            tx_q    <= '0;
            lft_q   <= '0;
            rght_q  <= '0;
            batt_q  <= '0;
        end else begin
            wrt_q <= 1'b0;
            case (state_q)
                IDLE: if (nxt) begin
                    tx_q    <= {2'b00, chnl_sel, 11'h000};
                    wrt_q   <= 1'b1;
                    state_q <= CMD;
                end
                CMD: if (done) state_q <= WAIT;
                WAIT: begin
                    tx_q    <= 16'h0000;
                    wrt_q   <= 1'b1;
                    state_q <= READ;
                end
                READ: if (done) begin
                    case (ptr_q)
                        PTR_LFT:  lft_q  <= rd_data[11:0];
                        PTR_RGHT: rght_q <= rd_data[11:0];
                        PTR_BATT: batt_q <= rd_data[11:0];
                        default:  ;
                    endcase
                    ptr_q   <= ptr_next(ptr_q);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt_q),
        .wt_data (tx_q),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;

endmodule

// File: tb/tb_a2d_intf.sv
// ----------------------------------------------------------------------------
// tb_a2d_intf
// Scoreboard bench for a2d_intf with a behavioural SPI ADC model. The ADC
// answers each frame with the value of the channel named in the previous
// frame's command word.
// ----------------------------------------------------------------------------
module tb_a2d_intf;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        nxt   = 1'b0;
    logic        MISO  = 1'b0;
    wire         SS_n;
    wire         SCLK;
    wire         MOSI;
    wire  [11:0] lft_ld;
    wire  [11:0] rght_ld;
    wire  [11:0] batt;

    a2d_intf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .nxt     (nxt),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .lft_ld  (lft_ld),
        .rght_ld (rght_ld),
        .batt    (batt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          idx;
        logic [11:0] val;
        logic [15:0] cmd;
        int          samp;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] adc_val[8];
    int          chan_tab[3];
    int          ptr_m = 0;

    // ---------------- ADC model ----------------
    logic        ss_m_prev   = 1'b1;
    logic        sclk_m_prev = 1'b1;
    logic [15:0] mosi_word   = '0;
    logic [15:0] miso_word   = '0;
    logic [15:0] last_word   = '0;
    int          rises_m     = 0;
    int          falls_m     = 0;
    int          last_ch     = 0;

    always @(SS_n or SCLK) begin
        if (ss_m_prev && !SS_n) begin
            mosi_word = '0;
            rises_m   = 0;
            falls_m   = 0;
            miso_word = {4'h0, adc_val[last_ch]};
            MISO      = 1'b0;
        end else if (!ss_m_prev && SS_n) begin
            if (rises_m == 16) begin
                last_word = mosi_word;
                last_ch   = int'(mosi_word[13:11]);
            end
        end
        if (!SS_n && !sclk_m_prev && SCLK) begin
            mosi_word = {mosi_word[14:0], MOSI};
            rises_m++;
        end
        if (!SS_n && sclk_m_prev && !SCLK && falls_m < 16) begin
            MISO = miso_word[15-falls_m];
            falls_m++;
        end
        ss_m_prev   = SS_n;
        sclk_m_prev = SCLK;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic run_monitor();
        logic        ss_prev   = 1'b1;
        logic        sclk_prev = 1'b1;
        logic        mosi_prev = 1'b0;
        int          low_cnt   = 0;
        int          rises     = 0;
        int          last_rise = -1;
        int          phase     = 0;
        bit          per_bad   = 0;
        bit          mosi_bad  = 0;
        bit          idle_bad  = 0;
        bit          aborted   = 1;
        logic [15:0] cmd_seen  = '0;
        logic [11:0] mdl[3];
        exp_t        e;
        for (int i = 0; i < 3; i++) mdl[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                for (int i = 0; i < 3; i++) mdl[i] = '0;
                phase   = 0;
                aborted = 1;
            end
            if (ss_prev && !SS_n) begin
                chk("sclk_idle_high", int'(idle_bad), 0);
                low_cnt   = 0;
                rises     = 0;
                last_rise = -1;
                per_bad   = 0;
                mosi_bad  = 0;
                idle_bad  = 0;
                aborted   = 0;
            end
            if (!SS_n) low_cnt++;
            if (!SS_n && !sclk_prev && SCLK) begin
                rises++;
                if (last_rise >= 0 && cyc - last_rise != 32) per_bad = 1;
                last_rise = cyc;
                if (MOSI !== mosi_prev) mosi_bad = 1;
            end
            if (SS_n && !SCLK) idle_bad = 1;
            if (!ss_prev && SS_n && !aborted) begin
                chk("ss_low_clks", low_cnt, 528);
                chk("sclk_rises", rises, 16);
                chk("sclk_period", int'(per_bad), 0);
                chk("mosi_stable", int'(mosi_bad), 0);
                if (phase == 0) begin
                    cmd_seen = last_word;
                    phase    = 1;
                end else begin
                    phase = 0;
                    chk("result_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        mdl[e.idx] = e.val;
                        chk("cmd_word", int'(cmd_seen), int'(e.cmd));
                        chk("read_word", int'(last_word), 0);
                        chk("latency", cyc - e.samp, 1059);
                        chk("lft_ld", int'(lft_ld), int'(mdl[0]));
                        chk("rght_ld", int'(rght_ld), int'(mdl[1]));
                        chk("batt", int'(batt), int'(mdl[2]));
                    end
                end
            end
            ss_prev   = SS_n;
            sclk_prev = SCLK;
            mosi_prev = MOSI;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic reset_checks();
        chk("rst_ss_n", int'(SS_n), 1);
        chk("rst_sclk", int'(SCLK), 1);
        chk("rst_mosi", int'(MOSI), 0);
        chk("rst_lft", int'(lft_ld), 0);
        chk("rst_rght", int'(rght_ld), 0);
        chk("rst_batt", int'(batt), 0);
    endtask

    task automatic issue();
        exp_t       e;
        logic [2:0] ch;
        ch     = 3'(chan_tab[ptr_m]);
        e.idx  = ptr_m;
        e.val  = adc_val[ch];
        e.cmd  = {2'b00, ch, 11'h000};
        e.samp = cyc + 1;
        exp_q.push_back(e);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        ptr_m = (ptr_m == 2) ? 0 : ptr_m + 1;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("conversion_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic randomize_adc();
        for (int k = 0; k < 8; k++) adc_val[k] = 12'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   t0;
        int   s0;
        exp_t e;

        chan_tab = '{0, 4, 5};
        for (int k = 0; k < 8; k++) adc_val[k] = '0;

        fork
            run_monitor();
        join_none

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        reset_checks();

        // single conversion of the left cell
        adc_val[0] = 12'hA5C;
        issue();
        wait_done(1500);

        // full round robin plus wrap back to left
        do_reset();
        adc_val[0] = 12'h111;
        adc_val[4] = 12'h444;
        adc_val[5] = 12'h555;
        for (int k = 0; k < 3; k++) begin
            issue();
            wait_done(1500);
        end
        adc_val[0] = 12'($urandom);
        issue();
        wait_done(1500);

        // nxt during CMD and READ is dropped
        issue();
        repeat (100) @(negedge clk);
        pulse_nxt();
        repeat (700) @(negedge clk);
        chk("in_read_frame", int'(SS_n), 0);
        pulse_nxt();
        wait_done(1500);
        repeat (1200) @(negedge clk);
        issue();
        wait_done(1500);

        // randomized conversions
        repeat (6) begin
            randomize_adc();
            issue();
            wait_done(1500);
        end

        // asynchronous abort 200 clk into the read frame
        do_reset();
        adc_val[0] = 12'($urandom_range(1, 4095));
        t0 = cyc;
        issue();
        while (cyc < t0 + 1 + 531 + 200) @(negedge clk);
        chk("ss_active_before_reset", int'(SS_n), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ss_n_high", int'(SS_n), 1);
        chk("abort_sclk_high", int'(SCLK), 1);
        chk("abort_lft_zero", int'(lft_ld), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        chk("post_abort_lft", int'(lft_ld), 0);
        issue();
        wait_done(1500);

        // nxt held high: back-to-back lft, rght, batt
        do_reset();
        randomize_adc();
        t0 = cyc;
        s0 = t0 + 1;
        for (int k = 0; k < 3; k++) begin
            e.idx  = k;
            e.val  = adc_val[chan_tab[k]];
            e.cmd  = {2'b00, 3'(chan_tab[k]), 11'h000};
            e.samp = s0 + k * 1060;
            exp_q.push_back(e);
        end
        nxt = 1'b1;
        while (cyc < s0 + 2 * 1060 + 1059) @(negedge clk);
        nxt = 1'b0;
        ptr_m = 0;
        wait_done(1500);
        repeat (1200) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
